// File: rtl/bufclr_pkg.sv
// bufclr_pkg: shared state encoding, frame codes and limits for the buffer-clear serializer
package bufclr_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BITA, S_BITB, S_GAP} state_t;
  localparam logic [1:0] CODE_EVEN = 2'b10;
  localparam logic [1:0] CODE_ODD  = 2'b01;
  localparam logic [1:0] CODE_BAD  = 2'b11;
  localparam int FRAME_LEN = 4;
  localparam logic [2:0] PEND_MAX = 3'd7;
endpackage

// File: rtl/bufclr_pend_cnt.sv
// bufclr_pend_cnt: 3-bit saturating pending-clear counter with registered overflow pulse
module bufclr_pend_cnt
  import bufclr_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       ovf
);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf   <= inc & ~dec & (count == PEND_MAX);
      count <= (inc & ~dec & (count != PEND_MAX)) ? count + 3'd1 :
               (dec & ~inc) ? count - 3'd1 : count;
    end
  end
endmodule

// File: rtl/bufclr_encoder.sv
// bufclr_encoder: serializes buffer-clear pulses into 3-bit UnDoBuf frames; BUFCLR_INJECT_EN adds InjErr illegal-frame injection
module bufclr_encoder
  import bufclr_pkg::*;
#(
  parameter int TBOARD = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ClrEven,
  input  logic       ClrOdd,
`ifdef BUFCLR_INJECT_EN
  input  logic       InjErr,
`endif
  output logic       UnDoBuf,
  output logic [2:0] NPendEven,
  output logic [2:0] NPendOdd,
  output logic       Busy,
  output logic       OvfErr
);
  state_t state, nxt;
  logic [1:0] code, code_nxt;
  logic rr_odd, inj_req, frame_edge, go, sel_even, sel_odd, pend_e, pend_o, ovf_e, ovf_o;
  assign frame_edge = (state == S_IDLE) || (state == S_GAP);
  assign pend_e     = |NPendEven;
  assign pend_o     = |NPendOdd;
  assign go         = frame_edge & (pend_e | pend_o | inj_req);
  assign sel_even   = go & ~inj_req & pend_e & (~pend_o | ~rr_odd);
  assign sel_odd    = go & ~inj_req & pend_o & (~pend_e | rr_odd);
  assign OvfErr     = ovf_e | ovf_o;
`ifdef BUFCLR_INJECT_EN
  logic inj_flag, sel_inj;
  assign inj_req  = inj_flag;
  assign sel_inj  = go & inj_flag;
  assign code_nxt = sel_inj ? CODE_BAD : sel_even ? CODE_EVEN : CODE_ODD;
  // a request arriving while the flag is being consumed starts a fresh one
  always_ff @(posedge Clock) begin
    if (Reset) inj_flag <= 1'b0;
    else       inj_flag <= InjErr | (inj_flag & ~sel_inj);
  end
`else
  assign inj_req  = 1'b0;
  assign code_nxt = sel_even ? CODE_EVEN : CODE_ODD;
`endif
  always_comb begin
    nxt = go ? S_START : frame_edge ? S_IDLE :
          (state == S_START) ? S_BITA : (state == S_BITA) ? S_BITB : S_GAP;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      code    <= '0;
      rr_odd  <= 1'b0;
      UnDoBuf <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= nxt;
      if (go) code <= code_nxt;
      if (sel_even | sel_odd) rr_odd <= ~rr_odd;
      UnDoBuf <= (nxt == S_START) | ((nxt == S_BITA) & code[1]) | ((nxt == S_BITB) & code[0]);
      Busy    <= nxt != S_IDLE;
    end
  end
  bufclr_pend_cnt u_even (
    .Clock(Clock), .Reset(Reset), .inc(ClrEven), .dec(sel_even), .count(NPendEven), .ovf(ovf_e)
  );
  generate
    if (TBOARD != 0) begin : g_odd
      bufclr_pend_cnt u_odd (
        .Clock(Clock), .Reset(Reset), .inc(ClrOdd), .dec(sel_odd), .count(NPendOdd), .ovf(ovf_o)
      );
    end else begin : g_vboard
      logic unused_odd;
      assign unused_odd = ClrOdd ^ sel_odd;
      assign NPendOdd   = '0;
      assign ovf_o      = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_bufclr_encoder.sv
// tb_bufclr_encoder: V- and T-board instances driven in lockstep, checked per cycle against a queue-based frame model
module tb_bufclr_encoder;
  logic clk = 0, rst = 1, clr_even = 0, clr_odd = 0, inj_err = 0;
  logic [1:0] u, b, o;
  logic [1:0][2:0] ne, no;
  typedef struct { logic u, b, o; int ne, no; } exp_t;
  exp_t sbq[2][$];
  int cnt_e[2], cnt_o[2];
  bit inj[2], rr[2];
  bit bits[2][$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bufclr_encoder #(.TBOARD(0)) dut_v (
    .Clock(clk), .Reset(rst), .ClrEven(clr_even), .ClrOdd(clr_odd),
`ifdef BUFCLR_INJECT_EN
    .InjErr(inj_err),
`endif
    .UnDoBuf(u[0]), .NPendEven(ne[0]), .NPendOdd(no[0]), .Busy(b[0]), .OvfErr(o[0])
  );
  bufclr_encoder #(.TBOARD(1)) dut_t (
    .Clock(clk), .Reset(rst), .ClrEven(clr_even), .ClrOdd(clr_odd),
`ifdef BUFCLR_INJECT_EN
    .InjErr(inj_err),
`endif
    .UnDoBuf(u[1]), .NPendEven(ne[1]), .NPendOdd(no[1]), .Busy(b[1]), .OvfErr(o[1])
  );

  // Line model: a queue of future serial bits; a new frame may be chosen only once the queue has drained
  task automatic step(int m);
    exp_t e;
    int s, x, y;
    bit pe, po;
    if (rst) begin
      cnt_e[m] = 0; cnt_o[m] = 0; inj[m] = 0; rr[m] = 0;
      bits[m].delete();
      e = '{0, 0, 0, 0, 0};
      sbq[m].push_back(e);
      return;
    end
    pe = cnt_e[m] > 0;
    po = (m == 1) && (cnt_o[m] > 0);
    s = 0;
    if (bits[m].size() == 0 && (pe || po || inj[m])) begin
      s = inj[m] ? 3 : (pe && po) ? (rr[m] ? 2 : 1) : pe ? 1 : 2;
      bits[m].push_back(1'b1);
      bits[m].push_back(s != 2);
      bits[m].push_back(s != 1);
      bits[m].push_back(1'b0);
      if (s != 3) rr[m] = !rr[m];
    end
    e.o = 0;
    x = cnt_e[m] + int'(clr_even) - int'(s == 1);
    if (x > 7) begin x = 7; e.o = 1; end
    y = cnt_o[m] + int'(m == 1 && clr_odd) - int'(s == 2);
    if (y > 7) begin y = 7; e.o = 1; end
    cnt_e[m] = x; cnt_o[m] = y;
    e.ne = x; e.no = y;
    inj[m] = inj_err | (inj[m] && s != 3);
    e.b = bits[m].size() > 0;
    e.u = e.b ? bits[m].pop_front() : 1'b0;
    sbq[m].push_back(e);
  endtask

  task automatic chk(int m, string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%s] t=%0t got %0d expected %0d", nm, (m != 0) ? "T" : "V", $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    step(0);
    step(1);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (sbq[m].size() > 0) begin
        e = sbq[m].pop_front();
        chk(m, "UnDoBuf", int'(u[m]), int'(e.u));
        chk(m, "Busy", int'(b[m]), int'(e.b));
        chk(m, "OvfErr", int'(o[m]), int'(e.o));
        chk(m, "NPendEven", int'(ne[m]), e.ne);
        chk(m, "NPendOdd", int'(no[m]), e.no);
      end
    end
  end

  task automatic cyc(bit r, bit ce, bit co, bit ij);
    @(negedge clk);
    rst = r;
    clr_even = ce;
    clr_odd = co;
`ifdef BUFCLR_INJECT_EN
    inj_err = ij;
`else
    if (ij) inj_err = 1'b0;
`endif
  endtask

  initial begin
    repeat (3) cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    repeat (12) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    repeat (14) cyc(0, 0, 0, 0);
    repeat (14) cyc(0, 1, 0, 0);
    repeat (40) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    repeat (12) cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 1, 1, 0);
    repeat (60) cyc(0, 0, 0, 0);
    repeat (1500)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
    repeat (800)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 12,
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 2);
    repeat (20) cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
